// File: rtl/and_pini_pipe_pkg.sv
// Purpose: shared sizing helpers for the pipelined PINI masked AND gadget.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Randomness layout per lane: low REF_NRND bits feed the refresh, high
// MUL_NRND bits feed the multiply. Both use one bit per unordered share pair.
package and_pini_pipe_pkg;

  function automatic int ref_nrnd(input int d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int mul_nrnd(input int d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int nrnd(input int d);
    return ref_nrnd(d) + mul_nrnd(d);
  endfunction

  function automatic int rnd_width(input int d, input int lanes);
    return lanes * nrnd(d);
  endfunction

  // Index of the randomness bit owned by share pair (i, j), i < j.
  // Pairs are enumerated row by row: (0,1),(0,2)..(0,d-1),(1,2),...
  function automatic int pair_idx(input int d, input int i, input int j);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/and_pini_pipe_if.sv
// Purpose: operand/result bundle of the masked AND pipeline.
// Latency: n/a (wires only).
// Backpressure: none; the pipeline accepts one operation per cycle.
//
// Signals: in_valid, zeroize, inb, ina, rnd (producer -> gadget);
//          out, out_valid (gadget -> consumer).
// Sharing layout: lane l share i at bit l*d+i.
interface and_pini_pipe_if #(
  parameter int d     = 2,
  parameter int LANES = 1
);
  import and_pini_pipe_pkg::*;

  localparam int RND_W = rnd_width(d, LANES);

  logic                  in_valid;
  logic                  zeroize;
  logic [LANES*d-1:0]    inb;
  logic [LANES*d-1:0]    ina;
  logic [RND_W-1:0]      rnd;
  logic [LANES*d-1:0]    out;
  logic                  out_valid;

  modport master (
    output in_valid, zeroize, inb, ina, rnd,
    input  out, out_valid
  );

  modport slave (
    input  in_valid, zeroize, inb, ina, rnd,
    output out, out_valid
  );

endinterface

// File: rtl/and_pini_pipe_lane.sv
// Purpose: one lane of the masked AND: refresh (or bypass) inb, delay it and
//          the multiply randomness, then a DOM-style registered multiply.
// Latency: inb/rnd at t, ina at t+RND_DLY, out at t+RND_DLY+1.
// Backpressure: none; every register advances each cycle.
//
// Ports: clk, rst (async, active-high), zeroize (sync clear),
//        inb/ina [d] shares, rnd [NRND] fresh bits, out [d] product shares.
module and_pini_pipe_lane import and_pini_pipe_pkg::*; #(
  parameter int d       = 2,
  parameter int RND_DLY = 3,
  parameter int REFRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 zeroize,
  input  logic [d-1:0]         inb,
  input  logic [d-1:0]         ina,
  input  logic [nrnd(d)-1:0]   rnd,
  output logic [d-1:0]         out
);

  localparam int   REF_N  = ref_nrnd(d);
  localparam int   MUL_N  = mul_nrnd(d);
  localparam logic REF_EN = (REFRESH != 0);

  logic [REF_N-1:0] rnd_ref;
  logic [MUL_N-1:0] rnd_mul;
  logic [d-1:0]     inb_fresh;

  logic [RND_DLY-1:0][d-1:0]     inb_dl_d, inb_dl_q;
  logic [RND_DLY-1:0][MUL_N-1:0] rmul_dl_d, rmul_dl_q;
  // term_q[i][j] is the registered partial product a_i*b_j (+ mask for i!=j);
  // registering each term before recombination keeps glitches domain-local.
  logic [d-1:0][d-1:0]           term_d, term_q;

  logic [d-1:0]     b_al;
  logic [MUL_N-1:0] r_al;

  assign rnd_ref = rnd[REF_N-1:0];
  assign rnd_mul = rnd[REF_N+MUL_N-1:REF_N];
  assign b_al    = inb_dl_q[RND_DLY-1];
  assign r_al    = rmul_dl_q[RND_DLY-1];

  // Each pair bit is added to both shares of its pair, so the refreshed
  // sharing still recombines to the same value. With the refresh disabled the
  // mask is gated off but the register stage stays, keeping latency fixed.
  always_comb begin
    inb_fresh = inb;
    for (int i = 0; i < d; i++) begin
      for (int j = i + 1; j < d; j++) begin
        inb_fresh[i] = inb_fresh[i] ^ (rnd_ref[pair_idx(d, i, j)] & REF_EN);
        inb_fresh[j] = inb_fresh[j] ^ (rnd_ref[pair_idx(d, i, j)] & REF_EN);
      end
    end
  end

  // Straight shift lines: randomness only moves forward and is never reused.
  always_comb begin
    inb_dl_d  = '0;
    rmul_dl_d = '0;
    if (!zeroize) begin
      inb_dl_d[0]  = inb_fresh;
      rmul_dl_d[0] = rnd_mul;
      for (int k = 1; k < RND_DLY; k++) begin
        inb_dl_d[k]  = inb_dl_q[k-1];
        rmul_dl_d[k] = rmul_dl_q[k-1];
      end
    end
  end

  // Cross terms (i,j) and (j,i) share one mask bit so the masks cancel when
  // all shares are recombined.
  always_comb begin
    term_d = '0;
    if (!zeroize) begin
      for (int i = 0; i < d; i++) begin
        for (int j = 0; j < d; j++) begin
          if (i == j)
            term_d[i][j] = ina[i] & b_al[j];
          else if (i < j)
            term_d[i][j] = (ina[i] & b_al[j]) ^ r_al[pair_idx(d, i, j)];
          else
            term_d[i][j] = (ina[i] & b_al[j]) ^ r_al[pair_idx(d, j, i)];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inb_dl_q  <= '0;
      rmul_dl_q <= '0;
      term_q    <= '0;
    end else begin
      inb_dl_q  <= inb_dl_d;
      rmul_dl_q <= rmul_dl_d;
      term_q    <= term_d;
    end
  end

  // Output share i compresses only its own registered domain terms.
  always_comb begin
    out = '0;
    for (int i = 0; i < d; i++) out[i] = ^term_q[i];
  end

endmodule

// File: rtl/and_pini_pipe.sv
// Purpose: LANES-wide pipelined PINI masked AND; owns valid tracking and zeroize.
// Latency: out/out_valid at t+RND_DLY+1 for inb/rnd at t (ina at t+RND_DLY).
// Backpressure: none; one operation per cycle, never stalls.
//
// Ports: clk, rst (async, active-high), bus (slave side of and_pini_pipe_if).
module and_pini_pipe import and_pini_pipe_pkg::*; #(
  parameter int d       = 2,
  parameter int LANES   = 1,
  parameter int RND_DLY = 3,
  parameter int REFRESH = 1
) (
  input  logic            clk,
  input  logic            rst,
  and_pini_pipe_if.slave  bus
);

  localparam int NRND = nrnd(d);

  logic [RND_DLY:0] vld_d, vld_q;

  // Zeroize wins over a same-cycle in_valid: the new operation is dropped too.
  always_comb begin
    vld_d = '0;
    if (!bus.zeroize) vld_d = {vld_q[RND_DLY-1:0], bus.in_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign bus.out_valid = vld_q[RND_DLY];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    and_pini_pipe_lane #(
      .d       (d),
      .RND_DLY (RND_DLY),
      .REFRESH (REFRESH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .zeroize (bus.zeroize),
      .inb     (bus.inb[l*d +: d]),
      .ina     (bus.ina[l*d +: d]),
      .rnd     (bus.rnd[l*NRND +: NRND]),
      .out     (bus.out[l*d +: d])
    );
  end

endmodule
